// File: rtl/matmul_partition_pkg.sv
// Shared types, limits and the signed add helper for the matmul dot-product accumulator.
// MATMUL_ACC_SAT_EN selects saturating adds; when it is undefined, adds wrap two's-complement.
package matmul_partition_pkg;

   localparam int DIN_W  = 32;
   localparam int ACC_W  = 32;
   localparam int WIDE_W = 64;

   typedef logic signed [DIN_W-1:0]  prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [WIDE_W-1:0] wide_t;

   localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
   localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-1){1'b0}}});

   typedef struct packed {
      wide_t sum;
      logic  ovf;
   } add_res_t;

   // Operands arrive sign-extended into a wide container; w is the real result width (w < WIDE_W).
   function automatic add_res_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
      wide_t    hi;
      wide_t    lo;
      wide_t    s;
      add_res_t r;
      hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo    = -hi - wide_t'(1);
      s     = a + b;
      r.ovf = (s > hi) || (s < lo);
`ifdef MATMUL_ACC_SAT_EN
      if (s > hi)
         s = hi;
      else if (s < lo)
         s = lo;
`endif
      r.sum = s;
      return r;
   endfunction

endpackage

// File: rtl/matmul_partition_acc_outreg.sv
// One-entry valid/ready holding register: loads a finished element, holds it stable until drained.
// can_load is high when empty or draining this cycle, so a load and a drain may share an edge.
module matmul_partition_acc_outreg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_ovf,
   output logic         can_load,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_ovf
);

   assign can_load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_ovf   <= load_ovf;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/matmul_partition_acc_32s_k.sv
// Sums K signed products per element; result is valid the cycle after the K-th accept. Wraps, or saturates under MATMUL_ACC_SAT_EN.
// in_ready drops only when the final term arrives while the output register is full and not draining.
module matmul_partition_acc_32s_k
   import matmul_partition_pkg::*;
#(
   parameter int DIN_WIDTH = DIN_W,
   parameter int ACC_WIDTH = ACC_W,
   parameter int K         = 4,
   parameter int CNT_WIDTH = $clog2(K) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DIN_WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_ovf,
   output logic                 busy
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(K - 1);

   logic [ACC_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 ovf_q;
   logic                 last;
   logic                 accept;
   logic                 can_load;
   logic                 elem_ovf;
   logic [ACC_WIDTH:0]   add_res;
   wide_t                ext_in;
   wide_t                ext_acc;

   // Keeps only the result width and the overflow flag of the wide package add.
   function automatic logic [ACC_WIDTH:0] acc_add(input wide_t a, input wide_t b);
      add_res_t r;
      r = sat_add(a, b, ACC_WIDTH);
      return {r.ovf, r.sum[ACC_WIDTH-1:0]};
   endfunction

   assign ext_in  = {{(WIDE_W-DIN_WIDTH){in_data[DIN_WIDTH-1]}}, in_data};
   assign ext_acc = (cnt_q == '0) ? '0 : {{(WIDE_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
   assign add_res = acc_add(ext_acc, ext_in);

   // A stale flag from an earlier element must not leak into the first term.
   assign elem_ovf = add_res[ACC_WIDTH] | ((cnt_q != '0) & ovf_q);
   assign last     = (cnt_q == LAST);
   assign in_ready = !last || can_load;
   assign accept   = in_valid && in_ready && !clr;
   assign busy     = (cnt_q != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr || (accept && last)) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         acc_q <= add_res[ACC_WIDTH-1:0];
         cnt_q <= cnt_q + 1'b1;
         ovf_q <= elem_ovf;
      end
   end

   matmul_partition_acc_outreg #(
      .W(ACC_WIDTH)
   ) u_outreg (
      .clk      (clk),
      .reset    (reset),
      .load     (accept && last),
      .load_data(add_res[ACC_WIDTH-1:0]),
      .load_ovf (elem_ovf),
      .can_load (can_load),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf)
   );

endmodule

// File: tb/tb_matmul_partition_acc_32s_k.sv
// Directed vector table plus hand sequences and a throttled random stream for the K=4 dot-product accumulator.
module tb_matmul_partition_acc_32s_k;
   import matmul_partition_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matmul_partition_acc_32s_k dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf),
      .busy     (busy)
   );

   typedef struct {
      string       name;
      logic [31:0] d[4];
      logic [31:0] exp;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d,
                          input logic [31:0] exp_wrap, input logic [31:0] exp_sat, input logic ov);
      vec_t v;
      v.name = nm;
      v.d[0] = a;
      v.d[1] = b;
      v.d[2] = c;
      v.d[3] = d;
`ifdef MATMUL_ACC_SAT_EN
      v.exp = exp_sat;
`else
      v.exp = exp_wrap;
`endif
      v.ovf = ov;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drive at the falling edge; sample registered outputs 1ns later.
   task automatic beat(input logic [31:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] cur;
   logic [31:0] exp_v;
   longint      acc;
   int          nb;
   int          elems_in;
   int          got;

   initial begin
      add_vec("sum1234",  32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd10, 1'b0);
      add_vec("pos_ovf",  32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'h80000000, ACC_MAX, 1'b1);
      add_vec("neg3",     32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD,
              32'hFFFFFFF4, 32'hFFFFFFF4, 1'b0);
      add_vec("neg_ovf",  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h7FFFFFFF, ACC_MIN, 1'b1);
      add_vec("ovf_back", 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFE, 1'b1);
      add_vec("cancel",   32'd100, 32'hFFFFFFCE, 32'd25, 32'hFFFFFFB5, 32'd0, 32'd0, 1'b0);
      add_vec("neg1",     32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_out_ovf",   32'(out_ovf), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // Table: four beats per element with the consumer always ready.
      foreach (vecs[i]) begin
         for (int b = 0; b < 4; b++) begin
            beat(vecs[i].d[b]);
            chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
            chk({vecs[i].name, "_busy"}, 32'(busy), (b != 0) ? 32'd1 : 32'd0);
         end
         idle();
         chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
         chk({vecs[i].name, "_data"}, out_data, vecs[i].exp);
         chk({vecs[i].name, "_ovf"}, 32'(out_ovf), 32'(vecs[i].ovf));
         chk({vecs[i].name, "_busy_end"}, 32'(busy), 32'd0);
         idle();
         chk({vecs[i].name, "_valid_1cyc"}, 32'(out_valid), 32'd0);
      end

      // Backpressure: first element held, only the final term of the second stalls.
      @(negedge clk);
      out_ready = 1'b0;
      beat(32'd5);
      beat(32'hFFFFFFFB);
      beat(32'd7);
      beat(32'hFFFFFFF9);
      chk("bp_rdy_cnt3_empty", 32'(in_ready), 32'd1);
      beat(32'd2);
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_held_data", out_data, 32'd0);
      chk("bp_rdy_cnt0", 32'(in_ready), 32'd1);
      beat(32'd2);
      chk("bp_rdy_cnt1", 32'(in_ready), 32'd1);
      beat(32'd2);
      chk("bp_rdy_cnt2", 32'(in_ready), 32'd1);
      beat(32'd2);
      chk("bp_rdy_cnt3_full", 32'(in_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("bp_stall_rdy", 32'(in_ready), 32'd0);
         chk("bp_stall_data", out_data, 32'd0);
         chk("bp_stall_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      chk("bp_drain_first", out_data, 32'd0);
      idle();
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_data", out_data, 32'd8);
      chk("bp_second_ovf", 32'(out_ovf), 32'd0);
      idle();
      chk("bp_second_gone", 32'(out_valid), 32'd0);

      // clr drops a simultaneous beat and the partial sum.
      beat(32'd9);
      beat(32'd9);
      @(negedge clk);
      clr      = 1'b1;
      in_data  = 32'd9;
      in_valid = 1'b1;
      #1;
      chk("clr_busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("clr_busy_after", 32'(busy), 32'd0);
      chk("clr_no_output", 32'(out_valid), 32'd0);
      for (int b = 0; b < 4; b++) beat(32'd1);
      idle();
      chk("clr_next_valid", 32'(out_valid), 32'd1);
      chk("clr_next_data", out_data, 32'd4);
      idle();

      // Async reset mid-element with an element held in the output register.
      @(negedge clk);
      out_ready = 1'b0;
      for (int b = 0; b < 6; b++) beat(32'd1);
      idle();
      chk("rst_mid_valid", 32'(out_valid), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_out_ovf", 32'(out_ovf), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) beat(32'hFFFFFFFD);
      idle();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_data", out_data, 32'hFFFFFFF4);
      idle();

      // Random throttling on both sides against an in-order reference queue.
      acc      = 0;
      nb       = 0;
      elems_in = 0;
      got      = 0;
      cur      = 32'($urandom_range(0, 2097152)) - 32'd1048576;
      for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (elems_in < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = cur;
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               exp_v = exp_q.pop_front();
               chk("rand_elem", out_data, exp_v);
               chk("rand_ovf", 32'(out_ovf), 32'd0);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            acc += longint'($signed(cur));
            nb++;
            if (nb == 4) begin
               exp_q.push_back(acc[31:0]);
               acc = 0;
               nb  = 0;
               elems_in++;
            end
            cur = 32'($urandom_range(0, 2097152)) - 32'd1048576;
         end
      end
      in_valid = 1'b0;
      chk("rand_count", 32'(got), 32'd1000);
      chk("rand_leftover", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
